spi_prog_loader: RTL and testbench

- Host-side master that feeds the tiny processor's serial load/run interface, driving the processor's uio_in[2:0] (mode bits and mosi) and observing its done output (uio_out[3]).
- Accepts parallel commands over a valid/ready handshake:
  - instruction-word write
  - data-word write
  - run program
- Write commands are serialized into 12-bit frames on the processor's one-bit-per-clock shift buffer.
- Run commands hold the run encoding until the processor reports done, or until a timeout expires.

---
 rtl/spi_prog_loader_if.sv | 25 ++
 rtl/spi_prog_loader.sv | 145 ++++++++++++++
 tb/tb_spi_prog_loader.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_prog_loader_if.sv
// Command handshake between a host controller and spi_prog_loader.
// The master presents one command at a time; the slave raises cmd_ready only when idle.
interface spi_prog_loader_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_addr,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_addr,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/spi_prog_loader.sv
// Host-side loader for the tiny processor: serializes cache writes into 12-bit LSB-first
// frames and drives run mode until the processor reports done or a timeout expires.
module spi_prog_loader #(
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned RUN_GUARD   = 2,
    parameter int unsigned RUN_TIMEOUT = 255,
    parameter int unsigned TO_W        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_prog_loader_if.slave    cmd,
    input  logic                done_in,
    output logic [1:0]          mode_o,
    output logic                mosi_o,
    output logic                busy_o,
    output logic                run_done_o,
    output logic                timeout_o
);

    localparam int unsigned GapEff   = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int unsigned GuardEff = (RUN_GUARD < 1) ? 1 : RUN_GUARD;
    localparam int unsigned CntMax   = (GapEff > GuardEff) ?
                                       ((GapEff > 12) ? GapEff : 12) :
                                       ((GuardEff > 12) ? GuardEff : 12);
    localparam int unsigned CntW     = $clog2(CntMax);

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StGap,
        StRunGuard,
        StRunWait
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [11:0]       frame_q, frame_d;
    logic [1:0]        op_q, op_d;
    logic              run_done_q, run_done_d;
    logic              timeout_q, timeout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            to_q       <= '0;
            frame_q    <= '0;
            op_q       <= '0;
            run_done_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            frame_q    <= frame_d;
            op_q       <= op_d;
            run_done_q <= run_done_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        to_d       = to_q;
        frame_d    = frame_q;
        op_d       = op_q;
        run_done_d = 1'b0;
        timeout_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd.cmd_valid) begin
                    frame_d = {cmd.cmd_data, cmd.cmd_addr};
                    op_d    = cmd.cmd_op;
                    cnt_d   = '0;
                    to_d    = '0;
                    case (cmd.cmd_op)
                        2'b00, 2'b01: state_d = StShift;
                        2'b10:        state_d = StRunGuard;
                        default:      state_d = StIdle;
                    endcase
                end
            end
            StShift: begin
                if (cnt_q == CntW'(11)) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == CntW'(GapEff - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRunGuard: begin
                if (cnt_q == CntW'(GuardEff - 1)) begin
                    state_d = StRunWait;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRunWait: begin
                // done has priority over a timeout landing in the same cycle
                if (done_in) begin
                    state_d    = StGap;
                    run_done_d = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                    if ((RUN_TIMEOUT != 0) && (to_d == TO_W'(RUN_TIMEOUT))) begin
                        state_d   = StGap;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd.cmd_ready = (state_q == StIdle);
        busy_o        = ~cmd.cmd_ready;
        mode_o        = 2'b00;
        mosi_o        = 1'b0;
        unique case (state_q)
            StShift: begin
                mode_o = (op_q == 2'b00) ? 2'b01 : 2'b10;
                mosi_o = frame_q[cnt_q[3:0]];
            end
            StRunGuard: mode_o = 2'b11;
            // Drop run in the same cycle done rises so the processor never restarts
            StRunWait:  mode_o = done_in ? 2'b00 : 2'b11;
            default:    mode_o = 2'b00;
        endcase
        run_done_o = run_done_q;
        timeout_o  = timeout_q;
    end

endmodule

// File: tb/tb_spi_prog_loader.sv
// Bench for spi_prog_loader: a behavioural processor model consumes frames and runs,
// and expected frames, caches and accumulator come from a reference model of the rules.
module tb_spi_prog_loader;

    localparam int unsigned GAP   = 2;
    localparam int unsigned GUARD = 2;
    localparam int unsigned TMO   = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       done_in;
    logic [1:0] mode_o;
    logic       mosi_o;
    logic       busy_o;
    logic       run_done_o;
    logic       timeout_o;

    int vectors = 0;
    int miscompares = 0;

    spi_prog_loader_if cmd_if ();

    spi_prog_loader #(
        .GAP_CYCLES  (GAP),
        .RUN_GUARD   (GUARD),
        .RUN_TIMEOUT (TMO),
        .TO_W        (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd_if.slave),
        .done_in    (done_in),
        .mode_o     (mode_o),
        .mosi_o     (mosi_o),
        .busy_o     (busy_o),
        .run_done_o (run_done_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk = ~clk;

    // Processor model: shift buffer, caches, and a 3-instruction summing program.
    logic [11:0] sbuf = '0;
    logic [1:0]  last_mode = 2'b00;
    int          busy_cnt = 0;
    int          exec_count = 0;
    bit          force_busy = 1'b0;
    logic [7:0]  icache [16];
    logic [7:0]  dcache [16];
    logic [7:0]  acc = '0;

    assign done_in = !force_busy && (busy_cnt == 0);

    always @(posedge clk) begin
        if (mode_o == 2'b01 || mode_o == 2'b10) begin
            sbuf      <= {mosi_o, sbuf[11:1]};
            last_mode <= mode_o;
        end else if (last_mode != 2'b00) begin
            if (last_mode == 2'b01) icache[sbuf[3:0]] <= sbuf[11:4];
            else                    dcache[sbuf[3:0]] <= sbuf[11:4];
            last_mode <= 2'b00;
        end
        if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end else if (mode_o == 2'b11) begin
            busy_cnt   <= 4;
            exec_count <= exec_count + 1;
            acc        <= 8'(dcache[icache[0][3:0]] + dcache[icache[1][3:0]]
                             + dcache[icache[2][3:0]]);
        end
    end

    logic [7:0] exp_i [16];
    logic [7:0] exp_d [16];

    task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d);
        int w = 0;
        while (cmd_if.cmd_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (w >= 100) begin
            miscompares++;
            $display("FAIL issue_wait: cmd_ready=%b, want 1 within 100 cycles", cmd_if.cmd_ready);
        end
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_addr  = a;
        cmd_if.cmd_data  = d;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({cmd_if.cmd_ready, busy_o, mode_o, mosi_o, run_done_o, timeout_o} !== 7'b1000000) begin
            miscompares++;
            $display("FAIL reset_state: got %b want 1000000",
                     {cmd_if.cmd_ready, busy_o, mode_o, mosi_o, run_done_o, timeout_o});
        end
    endtask

    task automatic test_write(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d);
        logic [11:0] fr;
        logic [1:0]  em;
        logic [7:0]  got;
        int          low = 0;
        fr = {d, a};
        em = (op == 2'b00) ? 2'b01 : 2'b10;
        issue(op, a, d);
        for (int k = 0; k < 12; k++) begin
            vectors++;
            if ({mode_o, mosi_o} !== {em, fr[k]}) begin
                miscompares++;
                $display("FAIL write_shift k=%0d: mode/mosi %b%b want %b%b", k, mode_o, mosi_o,
                         em, fr[k]);
            end
            if (!cmd_if.cmd_ready) low++;
            @(negedge clk);
        end
        for (int g = 0; g < int'(GAP); g++) begin
            vectors++;
            if ({mode_o, mosi_o} !== 3'b000) begin
                miscompares++;
                $display("FAIL write_gap g=%0d: mode/mosi %b%b want 000", g, mode_o, mosi_o);
            end
            if (!cmd_if.cmd_ready) low++;
            @(negedge clk);
        end
        vectors++;
        if (cmd_if.cmd_ready !== 1'b1 || low != 12 + int'(GAP)) begin
            miscompares++;
            $display("FAIL write_ready: ready=%b low=%0d want 1 low=%0d", cmd_if.cmd_ready, low,
                     12 + GAP);
        end
        if (op == 2'b00) exp_i[a] = d;
        else             exp_d[a] = d;
        got = (op == 2'b00) ? icache[a] : dcache[a];
        vectors++;
        if (got !== d) begin
            miscompares++;
            $display("FAIL write_commit op=%0d addr=%0h: got %h want %h", op, a, got, d);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  a1, a2;
        logic [7:0]  d1, d2;
        logic [11:0] f1, f2;
        int          low = 0;
        int          w = 0;
        a1 = 4'($urandom_range(0, 15));
        a2 = 4'($urandom_range(0, 15));
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        f1 = {d1, a1};
        f2 = {d2, a2};
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'b00;
        cmd_if.cmd_addr  = a1;
        cmd_if.cmd_data  = d1;
        @(negedge clk);
        cmd_if.cmd_op   = 2'b01;
        cmd_if.cmd_addr = a2;
        cmd_if.cmd_data = d2;
        for (int k = 0; k < 12; k++) begin
            vectors++;
            if ({mode_o, mosi_o} !== {2'b01, f1[k]}) begin
                miscompares++;
                $display("FAIL b2b_first k=%0d: mode/mosi %b%b want 01%b", k, mode_o, mosi_o,
                         f1[k]);
            end
            low++;
            @(negedge clk);
        end
        while (!cmd_if.cmd_ready && low < 100) begin
            low++;
            @(negedge clk);
        end
        vectors++;
        if (low != 12 + int'(GAP)) begin
            miscompares++;
            $display("FAIL b2b_spacing: ready low %0d cycles, want %0d", low, 12 + GAP);
        end
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            vectors++;
            if ({mode_o, mosi_o} !== {2'b10, f2[k]}) begin
                miscompares++;
                $display("FAIL b2b_second k=%0d: mode/mosi %b%b want 10%b", k, mode_o, mosi_o,
                         f2[k]);
            end
            @(negedge clk);
        end
        while (!cmd_if.cmd_ready && w < 100) begin
            w++;
            @(negedge clk);
        end
        exp_i[a1] = d1;
        exp_d[a2] = d2;
        vectors++;
        if (icache[a1] !== d1 || dcache[a2] !== d2) begin
            miscompares++;
            $display("FAIL b2b_commit: icache %h dcache %h want %h %h", icache[a1], dcache[a2],
                     d1, d2);
        end
    endtask

    task automatic test_reset_mid_shift();
        issue(2'b00, 4'($urandom_range(0, 15)), 8'($urandom));
        repeat (6) @(negedge clk);
        vectors++;
        if (mode_o !== 2'b01) begin
            miscompares++;
            $display("FAIL rst_pre: mode %b want 01", mode_o);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({mode_o, mosi_o, run_done_o, timeout_o} !== 5'b00000) begin
            miscompares++;
            $display("FAIL rst_async: mode/mosi/pulses %b want 00000",
                     {mode_o, mosi_o, run_done_o, timeout_o});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if ({cmd_if.cmd_ready, mode_o, mosi_o, run_done_o, timeout_o} !== 6'b100000) begin
                miscompares++;
                $display("FAIL rst_after i=%0d: got %b want 100000", i,
                         {cmd_if.cmd_ready, mode_o, mosi_o, run_done_o, timeout_o});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_op11();
        issue(2'b11, 4'($urandom_range(0, 15)), 8'($urandom));
        for (int i = 0; i < 12; i++) begin
            vectors++;
            if ({cmd_if.cmd_ready, busy_o, mode_o, mosi_o} !== 5'b10000) begin
                miscompares++;
                $display("FAIL op11 i=%0d: ready/busy/mode/mosi %b want 10000", i,
                         {cmd_if.cmd_ready, busy_o, mode_o, mosi_o});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_run();
        logic [3:0] da [3];
        logic [7:0] exp_acc;
        int         e0;
        int         n = 0;
        int         w = 0;
        bit         seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            da[i] = 4'($urandom_range(0, 15));
            test_write(2'b01, da[i], 8'($urandom));
        end
        for (int i = 0; i < 3; i++) test_write(2'b00, 4'(i), {4'($urandom), da[i]});
        exp_acc = 8'(exp_d[exp_i[0][3:0]] + exp_d[exp_i[1][3:0]] + exp_d[exp_i[2][3:0]]);
        e0 = exec_count;
        issue(2'b10, 4'h0, 8'h00);
        while (n < 50) begin
            if (n >= int'(GUARD) && done_in) begin
                seen = 1'b1;
                vectors++;
                if (mode_o !== 2'b00) begin
                    miscompares++;
                    $display("FAIL run_done_mode: mode %b want 00", mode_o);
                end
                break;
            end
            vectors++;
            if (mode_o !== 2'b11) begin
                miscompares++;
                $display("FAIL run_mode n=%0d: mode %b want 11", n, mode_o);
            end
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL run_wait: done not seen in 50 cycles, want seen");
        end
        @(negedge clk);
        vectors++;
        if ({run_done_o, timeout_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL run_pulse: done/timeout %b want 10", {run_done_o, timeout_o});
        end
        @(negedge clk);
        vectors++;
        if ({run_done_o, timeout_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL run_pulse_end: done/timeout %b want 00", {run_done_o, timeout_o});
        end
        while (!cmd_if.cmd_ready && w < 100) begin
            w++;
            @(negedge clk);
        end
        vectors++;
        if (acc !== exp_acc || exec_count - e0 != 1) begin
            miscompares++;
            $display("FAIL run_result: acc %h execs %0d want %h 1", acc, exec_count - e0, exp_acc);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int low = 0;
        force_busy = 1'b1;
        issue(2'b10, 4'h0, 8'h00);
        while (mode_o == 2'b11 && n < 100) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n != int'(GUARD + TMO)) begin
            miscompares++;
            $display("FAIL to_len: run held %0d cycles want %0d", n, GUARD + TMO);
        end
        vectors++;
        if ({run_done_o, timeout_o, mode_o} !== 4'b0100) begin
            miscompares++;
            $display("FAIL to_pulse: done/timeout/mode %b want 0100",
                     {run_done_o, timeout_o, mode_o});
        end
        while (!cmd_if.cmd_ready && low < 100) begin
            if (low > 0) begin
                vectors++;
                if ({run_done_o, timeout_o} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL to_pulse_end: done/timeout %b want 00", {run_done_o, timeout_o});
                end
            end
            low++;
            @(negedge clk);
        end
        vectors++;
        if (low != int'(GAP)) begin
            miscompares++;
            $display("FAIL to_gap: ready low %0d cycles want %0d", low, GAP);
        end
        force_busy = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'b00;
        cmd_if.cmd_addr  = 4'h0;
        cmd_if.cmd_data  = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_write(2'b00, 4'h3, 8'hA5);
        test_write(2'b01, 4'hF, 8'h80);
        repeat (6) test_write(2'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
        test_back_to_back();
        test_reset_mid_shift();
        test_op11();
        test_run();
        test_timeout();
        test_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
